// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with simultaneous push/pop,
// programmable almost-full/almost-empty thresholds, occupancy count,
// synchronous flush and sticky overflow/underflow flags.
//
// Ports:
//   clk          - single clock, all state updates on posedge
//   reset        - synchronous, active-high
//   push, in     - write request and data (captured when accepted)
//   pop          - read request; out updates on the accepting edge
//   flush        - synchronous clear of contents (error flags kept)
//   clear_err    - clears overflow/underflow (a same-cycle new error wins)
//   out          - registered read data
//   empty, full, almost_empty, almost_full, count - registered status
//   overflow     - sticky: push while full and not popping
//   underflow    - sticky: pop while empty
module sync_fifo_param #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned DEPTHLOG2    = 4,
    parameter int unsigned AFULL_LEVEL  = DEPTH - 2,
    parameter int unsigned AEMPTY_LEVEL = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 flush,
    input  logic                 clear_err,
    input  logic [WIDTH-1:0]     in,
    output logic [WIDTH-1:0]     out,
    output logic                 empty,
    output logic                 full,
    output logic                 almost_empty,
    output logic                 almost_full,
    output logic [DEPTHLOG2:0]   count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int unsigned CW = DEPTHLOG2 + 1;
    localparam int unsigned PW = DEPTHLOG2;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr_next;
    logic [PW-1:0] wptr_next;
    logic [CW-1:0] count_next;
    logic          push_ok;
    logic          pop_ok;
    logic          ovf_set;
    logic          unf_set;
    logic          overflow_next;
    logic          underflow_next;

    // Accept/reject decisions and next-state; flush discards any push/pop.
    always_comb begin
        pop_ok         = 1'b0;
        push_ok        = 1'b0;
        ovf_set        = 1'b0;
        unf_set        = 1'b0;
        rptr_next      = rptr;
        wptr_next      = wptr;
        count_next     = count;

        if (flush) begin
            rptr_next  = '0;
            wptr_next  = '0;
            count_next = '0;
        end else begin
            pop_ok  = pop && !empty;
            // A pop in the same cycle frees the slot, so a full FIFO still accepts.
            push_ok = push && (!full || pop_ok);
            ovf_set = push && full && !pop_ok;
            unf_set = pop && empty;

            if (push_ok) wptr_next = wptr + PW'(1);
            if (pop_ok)  rptr_next = rptr + PW'(1);

            if (push_ok && !pop_ok)      count_next = count + CW'(1);
            else if (!push_ok && pop_ok) count_next = count - CW'(1);
        end

        // New error beats clear_err.
        overflow_next  = ovf_set || (overflow  && !clear_err);
        underflow_next = unf_set || (underflow && !clear_err);
    end

    // Pointers, count, read data, flags; status decoded from next count so it is registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            rptr         <= '0;
            wptr         <= '0;
            count        <= '0;
            out          <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            rptr         <= rptr_next;
            wptr         <= wptr_next;
            count        <= count_next;
            empty        <= (count_next == CW'(0));
            full         <= (count_next == CW'(DEPTH));
            almost_empty <= (count_next <= CW'(AEMPTY_LEVEL));
            almost_full  <= (count_next >= CW'(AFULL_LEVEL));
            overflow     <= overflow_next;
            underflow    <= underflow_next;
            if (pop_ok) out <= mem[rptr];
        end
    end

    // Storage array; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) mem[wptr] <= in;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param (WIDTH=8, DEPTH=16).
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       push;
    logic       pop;
    logic       flush;
    logic       clear_err;
    logic [7:0] in;
    logic [7:0] out;
    logic       empty;
    logic       full;
    logic       almost_empty;
    logic       almost_full;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_out;
    logic [7:0] q [$];
    logic [7:0] v;

    sync_fifo_param #(
        .WIDTH(8), .DEPTH(16), .DEPTHLOG2(4), .AFULL_LEVEL(14), .AEMPTY_LEVEL(2)
    ) dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .flush(flush),
        .clear_err(clear_err), .in(in), .out(out), .empty(empty), .full(full),
        .almost_empty(almost_empty), .almost_full(almost_full), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle at negedge, sample #1 after the posedge, then idle inputs.
    task automatic cycle(input logic p, input logic q_, input logic [7:0] d,
                         input logic f, input logic c);
        @(negedge clk);
        push = p; pop = q_; in = d; flush = f; clear_err = c;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; flush = 1'b0; clear_err = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_empty"}, 32'(empty), 32'd1);
        check({tag, "_full"},  32'(full),  32'd0);
        check({tag, "_ae"},    32'(almost_empty), 32'd1);
        check({tag, "_af"},    32'(almost_full),  32'd0);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_ovf"},   32'(overflow),  32'd0);
        check({tag, "_unf"},   32'(underflow), 32'd0);
        check({tag, "_out"},   32'(out), 32'd0);
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; clear_err = 1'b0; in = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_state("reset");

        // Fill 0x00..0x0F; thresholds and full tracked per push.
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
            check("fill_count", 32'(count), 32'(i + 1));
            check("fill_af",    32'(almost_full),  32'((i + 1) >= 14));
            check("fill_ae",    32'(almost_empty), 32'((i + 1) <= 2));
            check("fill_full",  32'(full),  32'((i + 1) == 16));
            check("fill_empty", 32'(empty), 32'd0);
        end

        // Push while full: dropped, overflow sticky.
        cycle(1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);
        check("ovf_flag",  32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd16);
        check("ovf_out",   32'(out), 32'd0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_clear", 32'(overflow), 32'd0);

        // Push+pop at full: both accepted, no overflow.
        cycle(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
        check("pp_full_out",   32'(out), 32'h00);
        check("pp_full_count", 32'(count), 32'd16);
        check("pp_full_ovf",   32'(overflow), 32'd0);

        // Drain: 0x01..0x0F then 0x55; 0xAA never appears.
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
            exp_out = (i == 15) ? 8'h55 : 8'(i + 1);
            check("drain_out",   32'(out), 32'(exp_out));
            check("drain_count", 32'(count), 32'(15 - i));
            check("drain_ae",    32'(almost_empty), 32'((15 - i) <= 2));
            check("drain_empty", 32'(empty), 32'((15 - i) == 0));
        end
        exp_out = 8'h55;

        // Pop at empty: underflow, out holds.
        cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        check("unf_flag",  32'(underflow), 32'd1);
        check("unf_out",   32'(out), 32'(exp_out));
        check("unf_count", 32'(count), 32'd0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("unf_clear", 32'(underflow), 32'd0);
        check("unf_clear_ovf", 32'(overflow), 32'd0);

        // Push+pop at empty: push accepted, pop rejected.
        cycle(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
        check("pp_empty_count", 32'(count), 32'd1);
        check("pp_empty_unf",   32'(underflow), 32'd1);
        check("pp_empty_out",   32'(out), 32'(exp_out));
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("pp_empty_clr", 32'(underflow), 32'd0);
        cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        exp_out = 8'h77;
        check("pp_empty_read", 32'(out), 32'h77);
        check("pp_empty_cnt0", 32'(count), 32'd0);

        // clear_err together with a fresh underflow: set wins.
        cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        check("set_wins", 32'(underflow), 32'd1);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("set_wins_clr", 32'(underflow), 32'd0);

        // Wrap-around at count 8 with scoreboard queue.
        v = 8'h20;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, v, 1'b0, 1'b0);
            q.push_back(v);
            v = v + 8'd1;
        end
        check("wrap_fill", 32'(count), 32'd8);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'b1, v, 1'b0, 1'b0);
            q.push_back(v);
            v = v + 8'd1;
            exp_out = q.pop_front();
            check("wrap_out",   32'(out), 32'(exp_out));
            check("wrap_count", 32'(count), 32'd8);
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
            exp_out = q.pop_front();
            check("wrap_drain", 32'(out), 32'(exp_out));
        end
        check("wrap_empty", 32'(empty), 32'd1);

        // Flush with push at count 9: contents gone, push discarded, flags kept.
        cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        check("fl_unf_set", 32'(underflow), 32'd1);
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 8'(8'h90 + i), 1'b0, 1'b0);
        check("fl_pre_count", 32'(count), 32'd9);
        cycle(1'b1, 1'b0, 8'hEE, 1'b1, 1'b0);
        check("fl_count", 32'(count), 32'd0);
        check("fl_empty", 32'(empty), 32'd1);
        check("fl_ae",    32'(almost_empty), 32'd1);
        check("fl_unf",   32'(underflow), 32'd1);
        check("fl_ovf",   32'(overflow), 32'd0);
        check("fl_out",   32'(out), 32'(exp_out));
        cycle(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        check("fl_after_out",   32'(out), 32'h3C);
        check("fl_after_count", 32'(count), 32'd0);

        // Reset with overflow set: everything back to reset values.
        for (int i = 0; i < 17; i++) cycle(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
        check("rst_pre_ovf",  32'(overflow), 32'd1);
        check("rst_pre_full", 32'(full), 32'd1);
        @(negedge clk);
        reset = 1'b1; push = 1'b1; pop = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0; push = 1'b0; pop = 1'b0;
        check_reset_state("rst2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO: the next generation of the team's push/pop buffer. It is generalised in width and depth and supports simultaneous push and pop. It adds programmable almost-full/almost-empty thresholds, an occupancy count, a synchronous flush, and sticky overflow/underflow error flags in place of testbench-only protection. It sits between a producer and a consumer in the same clock domain and replaces the fixed 8x16 FIFO in new designs.

## Interface
- WIDTH, 8, data width in bits (>=1)
- DEPTH, 16, number of entries; must equal 2**DEPTHLOG2
- DEPTHLOG2, 4, pointer width (>=1)
- AFULL_LEVEL, DEPTH-2, almost_full asserted when count >= AFULL_LEVEL (1..DEPTH)
- AEMPTY_LEVEL, 2, almost_empty asserted when count <= AEMPTY_LEVEL (0..DEPTH-1)

Ports:
- clk  input  1  single clock; all state updates on posedge
- reset  input  1  synchronous, active-high
- push  input  1  write request; in captured at posedge when accepted
- pop  input  1  read request
- flush  input  1  synchronous clear of contents (not error flags)
- clear_err  input  1  clears overflow/underflow flags
- in  input  WIDTH  write data
- out  output  WIDTH  registered read data
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- almost_empty  output  1  count <= AEMPTY_LEVEL
- almost_full  output  1  count >= AFULL_LEVEL
- count  output  DEPTHLOG2+1  occupancy, 0..DEPTH
- overflow  output  1  sticky: push attempted while full and not popping
- underflow  output  1  sticky: pop attempted while empty

## Operation
- Storage: DEPTH x WIDTH register array; rptr/wptr are DEPTHLOG2 bits and wrap naturally (DEPTH-1 -> 0). count is tracked separately, and full/empty derive from count.
- Priority per edge: reset > flush > push/pop.
- Reset: rptr=wptr=0, count=0, out=0, overflow=underflow=0. Outputs: empty=1, full=0, almost_empty=1, almost_full=0 (AFULL_LEVEL>=1). Array contents are not cleared.
- flush: rptr=wptr=0, count=0; out holds its value; flags unchanged. A push or pop in the same cycle is discarded and does not set any flag.
- Accepted push (push_ok) = push && (!full || pop_ok): mem[wptr]<=in, wptr+1.
- Accepted pop (pop_ok) = pop && !empty: out<=mem[rptr], rptr+1.
- count next = count + push_ok - pop_ok; it never exceeds DEPTH and never goes below 0.
- Simultaneous push+pop:
  - not empty, not full: both accepted, count unchanged.
  - full: both accepted (pop frees the slot), no overflow.
  - empty: push accepted, pop rejected, underflow set, count becomes 1.
- Rejected push (push && full && !pop_ok): data dropped, overflow<=1.
- Rejected pop (pop && empty): out holds, underflow<=1.
- clear_err clears both flags. If a new error occurs in the same cycle as clear_err, the set wins.
- X on push/pop/flush is a protocol violation. The bound assertion module flags it; RTL behaviour is then undefined.

## Timing
- All outputs are registered or decoded from registered count. There is no combinational path from inputs to outputs.
- Write-to-read latency: a push at edge N makes empty=0 after edge N. The earliest pop is sampled at edge N+1, and the data appears on out after edge N+1.
- Pop latency: out updates on the same edge the pop is accepted, i.e. 1 cycle after pop is driven at the preceding negedge.
- Flags (empty/full/almost_*/count) reflect the state after the edge, so they are valid for the whole following cycle.
- overflow/underflow are visible the cycle after the offending edge.
- Reset or flush asserted mid-stream takes effect at the next posedge regardless of push/pop.

## Test plan
- Reset then fill/drain: push 0x00..0x0F (DEPTH=16), then pop 16 times -> out sequence 0x00..0x0F in order; full=1 after the 16th push; empty=1 after the 16th pop; count tracks 0..16..0.
- Thresholds: push 14 words -> almost_full rises exactly after the 14th push; pop down to 2 -> almost_empty rises after the pop that reaches count=2.
- Overflow/underflow: at full, push 0xAA -> overflow=1, count stays 16, 0xAA is never read. At empty, pop -> underflow=1, out unchanged. Then clear_err -> both flags 0.
- Simultaneous push+pop: at count=16, push 0x55 with pop -> count stays 16, no overflow, 0x55 is read last. At count=0, push+pop -> count=1, underflow=1.
- Wrap-around: 40 interleaved push/pop cycles at count~8 with an incrementing pattern -> data order preserved across pointer wraps, and the scoreboard matches.
- Flush/reset mid-operation: with count=9, assert flush together with push -> count=0, empty=1, flags unchanged. Assert reset with overflow=1 -> all outputs return to reset values.
